ram_arbiter_2to1: RTL and testbench

RAM_ARBITER_2TO1 -- requirements
Module: ram_arbiter_2to1

---
 rtl/ram_arbiter_2to1_if.sv | 16 +
 rtl/ram_arbiter_2to1.sv | 114 +++++++++++
 tb/tb_ram_arbiter_2to1.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_2to1_if.sv
// Request/grant bus between a memory master and a single-port RAM with in-order responses.
// The master modport issues commands; the slave modport answers them.
interface ram_arbiter_2to1_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/ram_arbiter_2to1.sv
// Two-master round-robin arbiter in front of one single-port RAM with zero added latency.
// An owner FIFO records who issued each outstanding command so in-order responses route back.
module ram_arbiter_2to1 #(
    parameter int MAX_OUT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_arbiter_2to1_if.slave     m0,
    ram_arbiter_2to1_if.slave     m1,
    ram_arbiter_2to1_if.master    s,
    output logic                  protocol_err
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [CW-1:0] count_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic          owner_q [MAX_OUT];
    logic          last_grant_q;
    logic          lock_q;
    logic          lock_sel_q;
    logic          err_q;

    logic any_req;
    logic full;
    logic sel;
    logic issue;
    logic push;
    logic pop;
    logic stray;
    logic head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(MAX_OUT - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Selection, issue and response routing are purely combinational; rst_n gates every output.
    always_comb begin
        any_req = m0.req | m1.req;
        full    = (count_q == CW'(MAX_OUT));
        issue   = rst_n & any_req & ~full;

        if (lock_q)
            sel = lock_sel_q;
        else if (m0.req & m1.req)
            sel = ~last_grant_q;
        else
            sel = m1.req;

        push  = issue & s.gnt;
        head  = owner_q[rd_ptr_q];
        pop   = rst_n & s.rvalid & (count_q != '0);
        stray = s.rvalid & (count_q == '0);

        s.req   = issue;
        s.we    = issue & (sel ? m1.we : m0.we);
        s.be    = issue ? (sel ? m1.be    : m0.be)    : '0;
        s.addr  = issue ? (sel ? m1.addr  : m0.addr)  : '0;
        s.wdata = issue ? (sel ? m1.wdata : m0.wdata) : '0;

        m0.gnt    = push & ~sel;
        m1.gnt    = push & sel;
        m0.rvalid = pop & ~head;
        m1.rvalid = pop & head;
        m0.err    = pop & ~head & s.err;
        m1.err    = pop & head & s.err;
        m0.rdata  = rst_n ? s.rdata : '0;
        m1.rdata  = rst_n ? s.rdata : '0;

        protocol_err = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            lock_q       <= 1'b0;
            lock_sel_q   <= 1'b0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q     <= ptr_inc(wr_ptr_q);
                last_grant_q <= sel;
                lock_q       <= 1'b0;
            end else if (issue) begin
                // Hold the pending command stable until the RAM accepts it.
                lock_q     <= 1'b1;
                lock_sel_q <= sel;
            end

            if (pop)
                rd_ptr_q <= ptr_inc(rd_ptr_q);

            if (push & ~pop)
                count_q <= count_q + 1'b1;
            else if (pop & ~push)
                count_q <= count_q - 1'b1;

            if (stray)
                err_q <= 1'b1;
        end
    end

    // Owner entries are only read below count, so they need no reset.
    always_ff @(posedge clk) begin
        if (push)
            owner_q[wr_ptr_q] <= sel;
    end

endmodule

// File: tb/tb_ram_arbiter_2to1.sv
// Directed bench for ram_arbiter_2to1 with MAX_OUT=2: tie round robin, lock, full, stray response,
// write path and reset in the middle of traffic.
module tb_ram_arbiter_2to1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic protocol_err;
    int   total = 0;
    int   bad = 0;

    ram_arbiter_2to1_if m0_bus ();
    ram_arbiter_2to1_if m1_bus ();
    ram_arbiter_2to1_if s_bus ();

    ram_arbiter_2to1 #(.MAX_OUT(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0           (m0_bus),
        .m1           (m1_bus),
        .s            (s_bus),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs;
        m0_bus.req = 0; m0_bus.we = 0; m0_bus.be = '0; m0_bus.addr = '0; m0_bus.wdata = '0;
        m1_bus.req = 0; m1_bus.we = 0; m1_bus.be = '0; m1_bus.addr = '0; m1_bus.wdata = '0;
        s_bus.gnt = 0; s_bus.rvalid = 0; s_bus.rdata = '0; s_bus.err = 0;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        m0_bus.req = 1; m0_bus.addr = 32'h123; s_bus.gnt = 1; s_bus.rvalid = 1; s_bus.rdata = 32'hDEAD;
        #1;
        total++; if (s_bus.req !== 1'b0) begin bad++; $display("FAIL rst_s_req: got %0b want 0", s_bus.req); end
        total++; if (s_bus.addr !== 32'h0) begin bad++; $display("FAIL rst_s_addr: got %0h want 0", s_bus.addr); end
        total++; if (m0_bus.gnt !== 1'b0) begin bad++; $display("FAIL rst_m0_gnt: got %0b want 0", m0_bus.gnt); end
        total++; if (m0_bus.rvalid !== 1'b0) begin bad++; $display("FAIL rst_m0_rvalid: got %0b want 0", m0_bus.rvalid); end
        total++; if (m0_bus.rdata !== 32'h0) begin bad++; $display("FAIL rst_m0_rdata: got %0h want 0", m0_bus.rdata); end
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL rst_perr: got %0b want 0", protocol_err); end
        @(posedge clk);
        idle_inputs();
        #1 rst_n = 1'b1;
        next_cycle();
        m0_bus.addr = 32'h55; m0_bus.be = 4'hF;
        #1;
        total++; if (s_bus.req !== 1'b0) begin bad++; $display("FAIL idle_s_req: got %0b want 0", s_bus.req); end
        total++; if (s_bus.addr !== 32'h0) begin bad++; $display("FAIL idle_s_addr: got %0h want 0", s_bus.addr); end
        total++; if (s_bus.be !== 4'h0) begin bad++; $display("FAIL idle_s_be: got %0h want 0", s_bus.be); end
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL idle_perr: got %0b want 0", protocol_err); end
        idle_inputs();
    endtask

    task automatic test_tie;
        apply_reset();
        m0_bus.addr = 32'h100; m1_bus.addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            m0_bus.req = 1; m1_bus.req = 1; s_bus.gnt = 1;
            s_bus.rvalid = (i > 0); s_bus.rdata = 32'(32'h1000 + i);
            #1;
            total++; if (m0_bus.gnt !== ((i % 2) == 0)) begin bad++; $display("FAIL tie_m0_gnt[%0d]: got %0b want %0b", i, m0_bus.gnt, (i % 2) == 0); end
            total++; if (m1_bus.gnt !== ((i % 2) == 1)) begin bad++; $display("FAIL tie_m1_gnt[%0d]: got %0b want %0b", i, m1_bus.gnt, (i % 2) == 1); end
            total++; if (s_bus.addr !== (((i % 2) == 1) ? 32'h200 : 32'h100)) begin bad++; $display("FAIL tie_s_addr[%0d]: got %0h", i, s_bus.addr); end
            if (i > 0) begin
                total++; if (m0_bus.rvalid !== (((i - 1) % 2) == 0)) begin bad++; $display("FAIL tie_m0_rvalid[%0d]: got %0b want %0b", i, m0_bus.rvalid, ((i - 1) % 2) == 0); end
                total++; if (m1_bus.rvalid !== (((i - 1) % 2) == 1)) begin bad++; $display("FAIL tie_m1_rvalid[%0d]: got %0b want %0b", i, m1_bus.rvalid, ((i - 1) % 2) == 1); end
                total++; if (m0_bus.rdata !== 32'(32'h1000 + i)) begin bad++; $display("FAIL tie_m0_rdata[%0d]: got %0h want %0h", i, m0_bus.rdata, 32'h1000 + i); end
            end
        end
        next_cycle();
        m0_bus.req = 0; m1_bus.req = 0; s_bus.rvalid = 1;
        #1;
        total++; if (m1_bus.rvalid !== 1'b1) begin bad++; $display("FAIL tie_last_m1_rvalid: got %0b want 1", m1_bus.rvalid); end
        total++; if (m0_bus.rvalid !== 1'b0) begin bad++; $display("FAIL tie_last_m0_rvalid: got %0b want 0", m0_bus.rvalid); end
        total++; if (s_bus.req !== 1'b0) begin bad++; $display("FAIL tie_last_s_req: got %0b want 0", s_bus.req); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_lock;
        apply_reset();
        next_cycle();
        m1_bus.req = 1; m1_bus.addr = 32'h40; m0_bus.addr = 32'h80;
        #1;
        total++; if (s_bus.req !== 1'b1) begin bad++; $display("FAIL lock_c1_s_req: got %0b want 1", s_bus.req); end
        total++; if (m1_bus.gnt !== 1'b0) begin bad++; $display("FAIL lock_c1_m1_gnt: got %0b want 0", m1_bus.gnt); end
        next_cycle();
        m0_bus.req = 1;
        #1;
        total++; if (s_bus.addr !== 32'h40) begin bad++; $display("FAIL lock_c2_s_addr: got %0h want 40", s_bus.addr); end
        total++; if (m0_bus.gnt !== 1'b0) begin bad++; $display("FAIL lock_c2_m0_gnt: got %0b want 0", m0_bus.gnt); end
        next_cycle();
        #1;
        total++; if (s_bus.addr !== 32'h40) begin bad++; $display("FAIL lock_c3_s_addr: got %0h want 40", s_bus.addr); end
        next_cycle();
        s_bus.gnt = 1;
        #1;
        total++; if (m1_bus.gnt !== 1'b1) begin bad++; $display("FAIL lock_c4_m1_gnt: got %0b want 1", m1_bus.gnt); end
        total++; if (m0_bus.gnt !== 1'b0) begin bad++; $display("FAIL lock_c4_m0_gnt: got %0b want 0", m0_bus.gnt); end
        total++; if (s_bus.addr !== 32'h40) begin bad++; $display("FAIL lock_c4_s_addr: got %0h want 40", s_bus.addr); end
        next_cycle();
        m1_bus.req = 0;
        #1;
        total++; if (m0_bus.gnt !== 1'b1) begin bad++; $display("FAIL lock_c5_m0_gnt: got %0b want 1", m0_bus.gnt); end
        total++; if (s_bus.addr !== 32'h80) begin bad++; $display("FAIL lock_c5_s_addr: got %0h want 80", s_bus.addr); end
        next_cycle();
        m0_bus.req = 0; s_bus.gnt = 0; s_bus.rvalid = 1;
        #1;
        total++; if (m1_bus.rvalid !== 1'b1) begin bad++; $display("FAIL lock_r1_m1_rvalid: got %0b want 1", m1_bus.rvalid); end
        total++; if (m0_bus.rvalid !== 1'b0) begin bad++; $display("FAIL lock_r1_m0_rvalid: got %0b want 0", m0_bus.rvalid); end
        next_cycle();
        #1;
        total++; if (m0_bus.rvalid !== 1'b1) begin bad++; $display("FAIL lock_r2_m0_rvalid: got %0b want 1", m0_bus.rvalid); end
        total++; if (m1_bus.rvalid !== 1'b0) begin bad++; $display("FAIL lock_r2_m1_rvalid: got %0b want 0", m1_bus.rvalid); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_full;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            m0_bus.req = 1; s_bus.gnt = 1;
            #1;
            total++; if (m0_bus.gnt !== 1'b1) begin bad++; $display("FAIL full_grant[%0d]: got %0b want 1", i, m0_bus.gnt); end
        end
        next_cycle();
        #1;
        total++; if (s_bus.req !== 1'b0) begin bad++; $display("FAIL full_blocked_s_req: got %0b want 0", s_bus.req); end
        total++; if (m0_bus.gnt !== 1'b0) begin bad++; $display("FAIL full_blocked_m0_gnt: got %0b want 0", m0_bus.gnt); end
        next_cycle();
        s_bus.rvalid = 1;
        #1;
        total++; if (s_bus.req !== 1'b0) begin bad++; $display("FAIL full_pop_s_req: got %0b want 0", s_bus.req); end
        total++; if (m0_bus.rvalid !== 1'b1) begin bad++; $display("FAIL full_pop_m0_rvalid: got %0b want 1", m0_bus.rvalid); end
        next_cycle();
        s_bus.rvalid = 0;
        #1;
        total++; if (s_bus.req !== 1'b1) begin bad++; $display("FAIL full_resume_s_req: got %0b want 1", s_bus.req); end
        total++; if (m0_bus.gnt !== 1'b1) begin bad++; $display("FAIL full_resume_m0_gnt: got %0b want 1", m0_bus.gnt); end
        next_cycle();
        #1;
        total++; if (s_bus.req !== 1'b0) begin bad++; $display("FAIL full_refill_s_req: got %0b want 0", s_bus.req); end
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            m0_bus.req = 0; s_bus.gnt = 0; s_bus.rvalid = 1;
            #1;
            total++; if (m0_bus.rvalid !== 1'b1) begin bad++; $display("FAIL full_drain_m0_rvalid[%0d]: got %0b want 1", i, m0_bus.rvalid); end
        end
        next_cycle();
        s_bus.rvalid = 0;
        #1;
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL full_perr: got %0b want 0", protocol_err); end
        idle_inputs();
    endtask

    task automatic test_stray;
        apply_reset();
        next_cycle();
        s_bus.rvalid = 1; s_bus.rdata = 32'h5A5A;
        #1;
        total++; if (m0_bus.rvalid !== 1'b0) begin bad++; $display("FAIL stray_m0_rvalid: got %0b want 0", m0_bus.rvalid); end
        total++; if (m1_bus.rvalid !== 1'b0) begin bad++; $display("FAIL stray_m1_rvalid: got %0b want 0", m1_bus.rvalid); end
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL stray_perr_early: got %0b want 0", protocol_err); end
        next_cycle();
        s_bus.rvalid = 0;
        #1;
        total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL stray_perr_set: got %0b want 1", protocol_err); end
        repeat (3) next_cycle();
        total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL stray_perr_sticky: got %0b want 1", protocol_err); end
        rst_n = 1'b0;
        #1;
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL stray_perr_clear: got %0b want 0", protocol_err); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_write;
        apply_reset();
        next_cycle();
        m1_bus.req = 1; m1_bus.we = 1; m1_bus.be = 4'b0101; m1_bus.wdata = 32'hAABBCCDD; m1_bus.addr = 32'h8;
        s_bus.gnt = 1;
        #1;
        total++; if (s_bus.we !== 1'b1) begin bad++; $display("FAIL wr_s_we: got %0b want 1", s_bus.we); end
        total++; if (s_bus.be !== 4'b0101) begin bad++; $display("FAIL wr_s_be: got %0b want 0101", s_bus.be); end
        total++; if (s_bus.wdata !== 32'hAABBCCDD) begin bad++; $display("FAIL wr_s_wdata: got %0h want aabbccdd", s_bus.wdata); end
        total++; if (s_bus.addr !== 32'h8) begin bad++; $display("FAIL wr_s_addr: got %0h want 8", s_bus.addr); end
        total++; if (m1_bus.gnt !== 1'b1) begin bad++; $display("FAIL wr_m1_gnt: got %0b want 1", m1_bus.gnt); end
        next_cycle();
        m1_bus.req = 0; m1_bus.we = 0; s_bus.gnt = 0; s_bus.rvalid = 1; s_bus.err = 1;
        #1;
        total++; if (m1_bus.rvalid !== 1'b1) begin bad++; $display("FAIL wr_m1_rvalid: got %0b want 1", m1_bus.rvalid); end
        total++; if (m1_bus.err !== 1'b1) begin bad++; $display("FAIL wr_m1_err: got %0b want 1", m1_bus.err); end
        total++; if (m0_bus.rvalid !== 1'b0) begin bad++; $display("FAIL wr_m0_rvalid: got %0b want 0", m0_bus.rvalid); end
        total++; if (m0_bus.err !== 1'b0) begin bad++; $display("FAIL wr_m0_err: got %0b want 0", m0_bus.err); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        apply_reset();
        m0_bus.addr = 32'h300; m1_bus.addr = 32'h400;
        next_cycle();
        m0_bus.req = 1; m1_bus.req = 1; s_bus.gnt = 1;
        #1;
        total++; if (m0_bus.gnt !== 1'b1) begin bad++; $display("FAIL mid_first_m0_gnt: got %0b want 1", m0_bus.gnt); end
        next_cycle();
        #1;
        total++; if (m1_bus.gnt !== 1'b1) begin bad++; $display("FAIL mid_second_m1_gnt: got %0b want 1", m1_bus.gnt); end
        next_cycle();
        s_bus.rvalid = 1; s_bus.rdata = 32'hCAFEF00D;
        #1 rst_n = 1'b0;
        #1;
        total++; if (s_bus.req !== 1'b0) begin bad++; $display("FAIL mid_s_req: got %0b want 0", s_bus.req); end
        total++; if (s_bus.addr !== 32'h0) begin bad++; $display("FAIL mid_s_addr: got %0h want 0", s_bus.addr); end
        total++; if (m0_bus.rvalid !== 1'b0) begin bad++; $display("FAIL mid_m0_rvalid: got %0b want 0", m0_bus.rvalid); end
        total++; if (m1_bus.rvalid !== 1'b0) begin bad++; $display("FAIL mid_m1_rvalid: got %0b want 0", m1_bus.rvalid); end
        total++; if (m0_bus.rdata !== 32'h0) begin bad++; $display("FAIL mid_m0_rdata: got %0h want 0", m0_bus.rdata); end
        total++; if (m0_bus.gnt !== 1'b0 || m1_bus.gnt !== 1'b0) begin bad++; $display("FAIL mid_gnt: got %0b%0b want 00", m1_bus.gnt, m0_bus.gnt); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        s_bus.rvalid = 0;
        #1;
        total++; if (m0_bus.gnt !== 1'b1) begin bad++; $display("FAIL mid_after_m0_gnt: got %0b want 1", m0_bus.gnt); end
        total++; if (m1_bus.gnt !== 1'b0) begin bad++; $display("FAIL mid_after_m1_gnt: got %0b want 0", m1_bus.gnt); end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_tie();
        test_lock();
        test_full();
        test_stray();
        test_write();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
